// File: rtl/usb_fs_out_ctrl.sv
// usb_fs_out_ctrl: OUT/SETUP receive-path protocol controller for a full-speed
// USB device. Tracks token + data transactions, forwards payload bytes (never
// the trailing CRC16) to the selected endpoint buffer and requests a handshake.
// Build option: define USB_OUT_TOGGLE_EN for per-endpoint data toggle tracking
// and retransmission detection; without it any valid DATA0/DATA1 is accepted.
module usb_fs_out_ctrl #(
  parameter int NUM_EP  = 4,
  parameter int MAX_PKT = 64,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [6:0]        dev_addr,
  input  logic              rx_pkt_start,
  input  logic              rx_pkt_end,
  input  logic [3:0]        rx_pid,
  input  logic [6:0]        rx_addr,
  input  logic [3:0]        rx_endp,
  input  logic              rx_valid_packet,
  input  logic              rx_data_put,
  input  logic [7:0]        rx_data,
  input  logic [NUM_EP-1:0] ep_out_ready,
  input  logic [NUM_EP-1:0] ep_stall,
  output logic [3:0]        ep_sel,
  output logic              ep_data_put,
  output logic [7:0]        ep_data,
  output logic              ep_commit,
  output logic              ep_abort,
  output logic              ep_setup,
  output logic              hs_req,
  output logic [3:0]        hs_pid,
  input  logic              hs_ack
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOKEN_CHK,
    S_DATA_WAIT,
    S_DATA_RX,
    S_DATA_CHK,
    S_HS
  } state_t;

  state_t      state;
  logic        tok_setup;
  logic [6:0]  tok_addr;
  logic [3:0]  tok_endp;
  logic [3:0]  data_pid;
  logic [7:0]  byte_cnt;
  logic        babble;
  logic [15:0] tmo_cnt;
  logic        vld_p0;
  logic        vld_p1;
  logic [7:0]  hold_p0;
  logic [7:0]  hold_p1;
  logic [15:0] ready_ext;
  logic [15:0] stall_ext;
`ifdef USB_OUT_TOGGLE_EN
  logic [15:0] toggle;
`endif

  // Endpoint flags widened to 16 so the 4-bit ep_sel always indexes in range
  assign ready_ext = 16'(ep_out_ready);
  assign stall_ext = 16'(ep_stall);

  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

  // Two-byte holding pipe: a byte is only released once two newer bytes
  // arrived, so the final two (CRC16) bytes are never forwarded
  always_ff @(posedge clk) begin
    if (state == S_DATA_RX && rx_data_put) begin
      hold_p1 <= hold_p0;
      hold_p0 <= rx_data;
    end
  end

  // Transaction FSM with registered endpoint and handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      tok_setup   <= 1'b0;
      tok_addr    <= '0;
      tok_endp    <= '0;
      data_pid    <= '0;
      byte_cnt    <= '0;
      babble      <= 1'b0;
      tmo_cnt     <= '0;
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      ep_sel      <= '0;
      ep_data_put <= 1'b0;
      ep_data     <= '0;
      ep_commit   <= 1'b0;
      ep_abort    <= 1'b0;
      ep_setup    <= 1'b0;
      hs_req      <= 1'b0;
      hs_pid      <= '0;
`ifdef USB_OUT_TOGGLE_EN
      toggle      <= '0;
`endif
    end else begin
      ep_data_put <= 1'b0;
      ep_commit   <= 1'b0;
      ep_abort    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_pkt_end && (rx_pid == PID_OUT || rx_pid == PID_SETUP)) begin
            tok_setup <= (rx_pid == PID_SETUP);
            tok_addr  <= rx_addr;
            tok_endp  <= rx_endp;
            state     <= S_TOKEN_CHK;
          end
        end
        S_TOKEN_CHK: begin
          if (rx_pkt_start) begin
            state <= S_IDLE;
          end else if (rx_valid_packet && tok_addr == dev_addr &&
                       {1'b0, tok_endp} < 5'(NUM_EP)) begin
            ep_sel   <= tok_endp;
            ep_setup <= tok_setup;
            byte_cnt <= '0;
            babble   <= 1'b0;
            tmo_cnt  <= '0;
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            state    <= S_DATA_WAIT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DATA_WAIT: begin
          if (rx_pkt_start) begin
            state <= S_DATA_RX;
          end else if (tmo_cnt == 16'(TIMEOUT - 1)) begin
            ep_setup <= 1'b0;
            state    <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_DATA_RX: begin
          if (rx_pkt_start) begin
            // framing error: drop anything already handed to the buffer
            ep_abort <= (byte_cnt != 8'd0) || babble;
            ep_setup <= 1'b0;
            state    <= S_IDLE;
          end else if (rx_pkt_end) begin
            data_pid <= rx_pid;
            state    <= S_DATA_CHK;
          end else if (rx_data_put) begin
            vld_p0 <= 1'b1;
            vld_p1 <= vld_p0;
            if (vld_p1) begin
              if (babble || byte_cnt == 8'(MAX_PKT)) begin
                babble <= 1'b1;
              end else begin
                ep_data_put <= 1'b1;
                ep_data     <= hold_p1;
                byte_cnt    <= byte_cnt + 8'd1;
              end
            end
          end
        end
        S_DATA_CHK: begin
          ep_setup <= 1'b0;
          state    <= S_IDLE;
          if (!rx_valid_packet || !is_data_pid(data_pid) || babble) begin
            ep_abort <= 1'b1;
          end else if (ep_setup) begin
            // SETUP must always be accepted regardless of halt state
            if (ready_ext[ep_sel]) begin
              ep_commit <= 1'b1;
              hs_req    <= 1'b1;
              hs_pid    <= PID_ACK;
              state     <= S_HS;
`ifdef USB_OUT_TOGGLE_EN
              toggle[ep_sel] <= 1'b1;
`endif
            end else begin
              ep_abort <= 1'b1;
            end
          end else if (stall_ext[ep_sel]) begin
            ep_abort <= 1'b1;
            hs_req   <= 1'b1;
            hs_pid   <= PID_STALL;
            state    <= S_HS;
          end else if (!ready_ext[ep_sel]) begin
            ep_abort <= 1'b1;
            hs_req   <= 1'b1;
            hs_pid   <= PID_NAK;
            state    <= S_HS;
          end else begin
            hs_req <= 1'b1;
            hs_pid <= PID_ACK;
            state  <= S_HS;
`ifdef USB_OUT_TOGGLE_EN
            // a mismatched toggle is a retransmission the host missed our ACK for
            if ((data_pid == PID_DATA1) == toggle[ep_sel]) begin
              ep_commit      <= 1'b1;
              toggle[ep_sel] <= ~toggle[ep_sel];
            end else begin
              ep_abort <= 1'b1;
            end
`else
            ep_commit <= 1'b1;
`endif
          end
        end
        S_HS: begin
          if (hs_ack) begin
            hs_req <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_fs_out_ctrl.sv
// Testbench for usb_fs_out_ctrl: randomized and directed transactions checked
// against a transaction-level reference model of the handshake rules.
module tb_usb_fs_out_ctrl;
  localparam int NUM_EP  = 4;
  localparam int MAX_PKT = 64;
  localparam int TIMEOUT = 64;

  localparam logic [3:0] P_OUT   = 4'b0001;
  localparam logic [3:0] P_SETUP = 4'b1101;
  localparam logic [3:0] P_IN    = 4'b1001;
  localparam logic [3:0] P_D0    = 4'b0011;
  localparam logic [3:0] P_D1    = 4'b1011;
  localparam logic [3:0] P_ACK   = 4'b0010;
  localparam logic [3:0] P_NAK   = 4'b1010;
  localparam logic [3:0] P_STALL = 4'b1110;

  logic              clk;
  logic              reset_n;
  logic [6:0]        dev_addr;
  logic              rx_pkt_start;
  logic              rx_pkt_end;
  logic [3:0]        rx_pid;
  logic [6:0]        rx_addr;
  logic [3:0]        rx_endp;
  logic              rx_valid_packet;
  logic              rx_data_put;
  logic [7:0]        rx_data;
  logic [NUM_EP-1:0] ep_out_ready;
  logic [NUM_EP-1:0] ep_stall;
  logic [3:0]        ep_sel;
  logic              ep_data_put;
  logic [7:0]        ep_data;
  logic              ep_commit;
  logic              ep_abort;
  logic              ep_setup;
  logic              hs_req;
  logic [3:0]        hs_pid;
  logic              hs_ack;

  usb_fs_out_ctrl #(.NUM_EP(NUM_EP), .MAX_PKT(MAX_PKT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .dev_addr(dev_addr),
    .rx_pkt_start(rx_pkt_start), .rx_pkt_end(rx_pkt_end), .rx_pid(rx_pid),
    .rx_addr(rx_addr), .rx_endp(rx_endp), .rx_valid_packet(rx_valid_packet),
    .rx_data_put(rx_data_put), .rx_data(rx_data),
    .ep_out_ready(ep_out_ready), .ep_stall(ep_stall), .ep_sel(ep_sel),
    .ep_data_put(ep_data_put), .ep_data(ep_data), .ep_commit(ep_commit),
    .ep_abort(ep_abort), .ep_setup(ep_setup), .hs_req(hs_req),
    .hs_pid(hs_pid), .hs_ack(hs_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor: cumulative event record sampled on the falling edge
  int         cyc = 0;
  logic [7:0] put_q[$];
  int         tot_commit = 0, tot_abort = 0, tot_hs = 0, tot_setup_puts = 0;
  int         last_pulse_cyc = 0, last_hs_cyc = 0;
  logic [3:0] last_hs_pid = '0;
  logic       hs_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ep_data_put) begin
      put_q.push_back(ep_data);
      if (ep_setup) tot_setup_puts <= tot_setup_puts + 1;
    end
    if (ep_commit) begin tot_commit <= tot_commit + 1; last_pulse_cyc <= cyc; end
    if (ep_abort)  begin tot_abort  <= tot_abort + 1;  last_pulse_cyc <= cyc; end
    if (hs_req && !hs_prev) begin
      tot_hs <= tot_hs + 1; last_hs_cyc <= cyc; last_hs_pid <= hs_pid;
    end
    hs_prev <= hs_req;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus data and per-transaction observations
  logic [7:0] pay [0:79];
  int         obs_base, obs_puts, obs_commit, obs_abort, obs_hs, obs_setup_puts;
  int         obs_end_cyc, obs_pulse_cyc, obs_hs_cyc;
  logic [3:0] obs_hs_pid;
  logic       obs_hs_seen, obs_hs_after, obs_hs_held;
  bit         tog [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives token, gap, data packet (payload + 2 CRC bytes) and answers hs_req
  task automatic send_txn(input logic [3:0] tpid, input logic [6:0] addr,
                          input logic [3:0] endp, input logic tvalid, input int gap,
                          input logic [3:0] dpid, input int n, input logic dvalid,
                          input int ack_dly);
    int c0, a0, h0, s0;
    c0 = tot_commit; a0 = tot_abort; h0 = tot_hs; s0 = tot_setup_puts;
    obs_base = put_q.size();
    obs_hs_seen = 1'b0; obs_hs_after = 1'b1; obs_hs_held = 1'b1;
    step(); rx_pkt_start = 1'b1; step(); rx_pkt_start = 1'b0; step();
    rx_pid = tpid; rx_addr = addr; rx_endp = endp; rx_valid_packet = tvalid;
    rx_pkt_end = 1'b1; step(); rx_pkt_end = 1'b0;
    repeat (gap) step();
    rx_pkt_start = 1'b1; step(); rx_pkt_start = 1'b0;
    for (int i = 0; i < n + 2; i++) begin
      if ($urandom_range(3) == 0) step();
      rx_data_put = 1'b1;
      rx_data = (i < n) ? pay[i] : 8'($urandom);
      step();
      rx_data_put = 1'b0;
    end
    rx_pid = dpid; rx_valid_packet = dvalid; rx_pkt_end = 1'b1;
    obs_end_cyc = cyc;
    step(); rx_pkt_end = 1'b0;
    for (int k = 0; k < 6 && !obs_hs_seen; k++) begin
      step();
      if (hs_req) begin
        obs_hs_seen = 1'b1;
        repeat (ack_dly) begin step(); if (!hs_req) obs_hs_held = 1'b0; end
        hs_ack = 1'b1; step(); hs_ack = 1'b0;
        obs_hs_after = hs_req;
      end
    end
    repeat (3) step();
    obs_puts = put_q.size() - obs_base;
    obs_commit = tot_commit - c0; obs_abort = tot_abort - a0; obs_hs = tot_hs - h0;
    obs_setup_puts = tot_setup_puts - s0;
    obs_pulse_cyc = last_pulse_cyc; obs_hs_cyc = last_hs_cyc; obs_hs_pid = last_hs_pid;
  endtask

  // Transaction-level model: res 0 none / 1 commit / 2 abort, hsp -1 = no handshake
  function automatic void model_txn(input logic [3:0] tpid, input logic [6:0] addr,
                                    input logic [3:0] endp, input logic tvalid,
                                    input logic [3:0] dpid, input int n, input logic dvalid,
                                    output int res, output int hsp, output int np);
    int e;
    e = int'(endp);
    res = 0; hsp = -1; np = 0;
    if (!(tpid == P_OUT || tpid == P_SETUP) || !tvalid || addr != dev_addr || e >= NUM_EP)
      return;
    np = (n > MAX_PKT) ? MAX_PKT : n;
    if (!dvalid || !(dpid == P_D0 || dpid == P_D1) || n > MAX_PKT) begin res = 2; return; end
    if (tpid == P_SETUP) begin
      if (ep_out_ready[e]) begin res = 1; hsp = int'(P_ACK); tog[e] = 1'b1; end
      else res = 2;
      return;
    end
    if (ep_stall[e])          begin res = 2; hsp = int'(P_STALL); return; end
    if (!ep_out_ready[e])     begin res = 2; hsp = int'(P_NAK);   return; end
    hsp = int'(P_ACK);
`ifdef USB_OUT_TOGGLE_EN
    if ((dpid == P_D1) == tog[e]) begin res = 1; tog[e] = !tog[e]; end
    else res = 2;
`else
    res = 1;
`endif
  endfunction

  task automatic test_reset();
    int c0, a0;
    reset_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({ep_sel, ep_data_put, ep_data, ep_commit, ep_abort, ep_setup, hs_req, hs_pid} !== 21'd0) begin
      n_fail++; $display("FAIL reset_outputs: got sel=%0d put=%0b setup=%0b hs=%0b want all 0",
                         ep_sel, ep_data_put, ep_setup, hs_req);
    end
    reset_n = 1'b1; step();
    // start a transaction to ep 1, then pull reset in the middle of the data
    step(); rx_pid = P_OUT; rx_addr = 7'd5; rx_endp = 4'd1; rx_valid_packet = 1'b1;
    rx_pkt_end = 1'b1; step(); rx_pkt_end = 1'b0;
    repeat (3) step(); rx_pkt_start = 1'b1; step(); rx_pkt_start = 1'b0;
    for (int i = 0; i < 5; i++) begin rx_data_put = 1'b1; rx_data = 8'(i + 1); step(); end
    rx_data_put = 1'b0;
    n_checks++;
    if (ep_sel !== 4'd1) begin n_fail++; $display("FAIL mid_ep_sel: got %0d want 1", ep_sel); end
    c0 = tot_commit; a0 = tot_abort;
    reset_n = 1'b0; #1;
    n_checks++;
    if ({ep_sel, ep_data_put, ep_data, ep_commit, ep_abort, ep_setup, hs_req, hs_pid} !== 21'd0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got sel=%0d put=%0b want all 0", ep_sel, ep_data_put);
    end
    repeat (3) step();
    reset_n = 1'b1; repeat (3) step();
    n_checks++;
    if ((tot_commit - c0) + (tot_abort - a0) != 0) begin
      n_fail++; $display("FAIL mid_reset_pulses: got %0d want 0", (tot_commit - c0) + (tot_abort - a0));
    end
    for (int i = 0; i < 16; i++) tog[i] = 1'b0;
  endtask

  task automatic test_out_ack();
    int res, hsp, np, bad;
    ep_out_ready = '1; ep_stall = '0;
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    model_txn(P_OUT, 7'd5, 4'd1, 1'b1, P_D0, 3, 1'b1, res, hsp, np);
    send_txn(P_OUT, 7'd5, 4'd1, 1'b1, 3, P_D0, 3, 1'b1, 0);
    n_checks++;
    if (obs_puts != 3) begin n_fail++; $display("FAIL out_ack_puts: got %0d want 3", obs_puts); end
    bad = 0;
    for (int i = 0; i < 3 && i < obs_puts; i++) if (put_q[obs_base + i] !== pay[i]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL out_ack_data: got %0d bad bytes want 0", bad); end
    n_checks++;
    if (obs_commit != 1 || obs_abort != 0) begin
      n_fail++; $display("FAIL out_ack_commit: got c=%0d a=%0d want c=1 a=0", obs_commit, obs_abort);
    end
    n_checks++;
    if (obs_hs != 1 || obs_hs_pid !== P_ACK) begin
      n_fail++; $display("FAIL out_ack_hs: got n=%0d pid=%b want n=1 pid=0010", obs_hs, obs_hs_pid);
    end
    n_checks++;
    if (obs_pulse_cyc != obs_end_cyc + 2 || obs_hs_cyc != obs_pulse_cyc) begin
      n_fail++; $display("FAIL out_ack_timing: got pulse=+%0d hs=+%0d want +2 +2",
                         obs_pulse_cyc - obs_end_cyc, obs_hs_cyc - obs_end_cyc);
    end
    n_checks++;
    if (obs_hs_after !== 1'b0) begin n_fail++; $display("FAIL out_ack_hs_drop: got %b want 0", obs_hs_after); end
  endtask

  task automatic test_retransmit();
    int res, hsp, np;
    model_txn(P_OUT, 7'd5, 4'd1, 1'b1, P_D0, 3, 1'b1, res, hsp, np);
    send_txn(P_OUT, 7'd5, 4'd1, 1'b1, 4, P_D0, 3, 1'b1, 0);
    n_checks++;
`ifdef USB_OUT_TOGGLE_EN
    if (obs_commit != 0 || obs_abort != 1 || obs_hs_pid !== P_ACK) begin
      n_fail++; $display("FAIL retx_d0: got c=%0d a=%0d pid=%b want c=0 a=1 pid=0010", obs_commit, obs_abort, obs_hs_pid);
    end
`else
    if (obs_commit != 1 || obs_abort != 0 || obs_hs_pid !== P_ACK) begin
      n_fail++; $display("FAIL retx_d0: got c=%0d a=%0d pid=%b want c=1 a=0 pid=0010", obs_commit, obs_abort, obs_hs_pid);
    end
`endif
    model_txn(P_OUT, 7'd5, 4'd1, 1'b1, P_D1, 3, 1'b1, res, hsp, np);
    send_txn(P_OUT, 7'd5, 4'd1, 1'b1, 4, P_D1, 3, 1'b1, 2);
    n_checks++;
    if (obs_commit != 1 || obs_abort != 0 || obs_hs_pid !== P_ACK) begin
      n_fail++; $display("FAIL next_d1: got c=%0d a=%0d pid=%b want c=1 a=0 pid=0010", obs_commit, obs_abort, obs_hs_pid);
    end
    n_checks++;
    if (obs_hs_held !== 1'b1 || obs_hs_after !== 1'b0) begin
      n_fail++; $display("FAIL hs_hold: got held=%b after=%b want 1 0", obs_hs_held, obs_hs_after);
    end
  endtask

  task automatic test_nak_stall();
    int res, hsp, np;
    ep_out_ready = 4'b1011; ep_stall = '0;
    model_txn(P_OUT, 7'd5, 4'd2, 1'b1, P_D0, 3, 1'b1, res, hsp, np);
    send_txn(P_OUT, 7'd5, 4'd2, 1'b1, 3, P_D0, 3, 1'b1, 0);
    n_checks++;
    if (obs_abort != 1 || obs_commit != 0 || obs_hs_pid !== P_NAK || obs_hs != 1) begin
      n_fail++; $display("FAIL nak: got a=%0d c=%0d pid=%b want a=1 c=0 pid=1010", obs_abort, obs_commit, obs_hs_pid);
    end
    ep_out_ready = '1; ep_stall = 4'b0100;
    model_txn(P_OUT, 7'd5, 4'd2, 1'b1, P_D0, 3, 1'b1, res, hsp, np);
    send_txn(P_OUT, 7'd5, 4'd2, 1'b1, 3, P_D0, 3, 1'b1, 0);
    n_checks++;
    if (obs_abort != 1 || obs_commit != 0 || obs_hs_pid !== P_STALL || obs_hs != 1) begin
      n_fail++; $display("FAIL stall: got a=%0d c=%0d pid=%b want a=1 c=0 pid=1110", obs_abort, obs_commit, obs_hs_pid);
    end
    ep_stall = '0;
  endtask

  task automatic test_setup();
    int res, hsp, np;
    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    for (int r = 0; r < 2; r++) begin
      ep_stall = (r == 1) ? 4'b0001 : 4'b0000;
      model_txn(P_SETUP, 7'd5, 4'd0, 1'b1, P_D0, 8, 1'b1, res, hsp, np);
      send_txn(P_SETUP, 7'd5, 4'd0, 1'b1, 3, P_D0, 8, 1'b1, 1);
      n_checks++;
      if (obs_setup_puts != 8 || obs_puts != 8) begin
        n_fail++; $display("FAIL setup_puts[%0d]: got setup=%0d puts=%0d want 8 8", r, obs_setup_puts, obs_puts);
      end
      n_checks++;
      if (obs_commit != 1 || obs_hs_pid !== P_ACK || obs_hs != 1) begin
        n_fail++; $display("FAIL setup_ack[%0d]: got c=%0d pid=%b want c=1 pid=0010", r, obs_commit, obs_hs_pid);
      end
      n_checks++;
      if (ep_setup !== 1'b0) begin n_fail++; $display("FAIL setup_clear[%0d]: got %b want 0", r, ep_setup); end
    end
    ep_stall = '0;
    // toggle[0] was forced to 1 by SETUP, so an OUT DATA0 is a retransmission
    model_txn(P_OUT, 7'd5, 4'd0, 1'b1, P_D0, 2, 1'b1, res, hsp, np);
    send_txn(P_OUT, 7'd5, 4'd0, 1'b1, 3, P_D0, 2, 1'b1, 0);
    n_checks++;
`ifdef USB_OUT_TOGGLE_EN
    if (obs_abort != 1 || obs_commit != 0 || obs_hs_pid !== P_ACK) begin
      n_fail++; $display("FAIL setup_toggle: got a=%0d c=%0d want a=1 c=0", obs_abort, obs_commit);
    end
`else
    if (obs_abort != 0 || obs_commit != 1 || obs_hs_pid !== P_ACK) begin
      n_fail++; $display("FAIL setup_toggle: got a=%0d c=%0d want a=0 c=1", obs_abort, obs_commit);
    end
`endif
  endtask

  task automatic test_babble_badcrc();
    int res, hsp, np, bad;
    for (int i = 0; i < 65; i++) pay[i] = 8'($urandom);
    model_txn(P_OUT, 7'd5, 4'd3, 1'b1, P_D1, 65, 1'b1, res, hsp, np);
    send_txn(P_OUT, 7'd5, 4'd3, 1'b1, 3, P_D1, 65, 1'b1, 0);
    n_checks++;
    if (obs_puts != 64) begin n_fail++; $display("FAIL babble_puts: got %0d want 64", obs_puts); end
    bad = 0;
    for (int i = 0; i < 64 && i < obs_puts; i++) if (put_q[obs_base + i] !== pay[i]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL babble_data: got %0d bad bytes want 0", bad); end
    n_checks++;
    if (obs_abort != 1 || obs_commit != 0 || obs_hs != 0) begin
      n_fail++; $display("FAIL babble_result: got a=%0d c=%0d hs=%0d want 1 0 0", obs_abort, obs_commit, obs_hs);
    end
    model_txn(P_OUT, 7'd5, 4'd3, 1'b1, P_D0, 3, 1'b0, res, hsp, np);
    send_txn(P_OUT, 7'd5, 4'd3, 1'b1, 3, P_D0, 3, 1'b0, 0);
    n_checks++;
    if (obs_puts != 3 || obs_abort != 1 || obs_commit != 0 || obs_hs != 0) begin
      n_fail++; $display("FAIL badcrc: got puts=%0d a=%0d c=%0d hs=%0d want 3 1 0 0", obs_puts, obs_abort, obs_commit, obs_hs);
    end
  endtask

  task automatic test_addr_timeout();
    send_txn(P_OUT, 7'd6, 4'd1, 1'b1, 3, P_D0, 3, 1'b1, 0);
    n_checks++;
    if (obs_puts + obs_commit + obs_abort + obs_hs != 0) begin
      n_fail++; $display("FAIL wrong_addr: got puts=%0d c=%0d a=%0d hs=%0d want all 0", obs_puts, obs_commit, obs_abort, obs_hs);
    end
    send_txn(P_OUT, 7'd5, 4'd1, 1'b1, TIMEOUT + 16, P_D0, 3, 1'b1, 0);
    n_checks++;
    if (obs_puts + obs_commit + obs_abort + obs_hs != 0) begin
      n_fail++; $display("FAIL timeout: got puts=%0d c=%0d a=%0d hs=%0d want all 0", obs_puts, obs_commit, obs_abort, obs_hs);
    end
    send_txn(P_OUT, 7'd5, 4'd4, 1'b1, 3, P_D0, 3, 1'b1, 0);
    n_checks++;
    if (obs_puts + obs_commit + obs_abort + obs_hs != 0) begin
      n_fail++; $display("FAIL bad_endp: got puts=%0d c=%0d a=%0d hs=%0d want all 0", obs_puts, obs_commit, obs_abort, obs_hs);
    end
  endtask

  task automatic test_random();
    int res, hsp, np, bad, r, n;
    logic [3:0] tpid, dpid, endp;
    logic [6:0] addr;
    logic tvalid, dvalid;
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(9));
      tpid = (r < 5) ? P_OUT : (r < 8) ? P_SETUP : (r == 8) ? P_IN : P_D0;
      addr = ($urandom_range(7) == 0) ? 7'd6 : 7'd5;
      endp = 4'($urandom_range(5));
      tvalid = ($urandom_range(9) != 0);
      r = int'($urandom_range(9));
      dpid = (r < 5) ? P_D0 : (r < 9) ? P_D1 : P_ACK;
      n = ($urandom_range(9) == 0) ? int'($urandom_range(66, 70)) : int'($urandom_range(0, 12));
      dvalid = ($urandom_range(9) != 0);
      ep_out_ready = 4'($urandom);
      ep_stall = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      model_txn(tpid, addr, endp, tvalid, dpid, n, dvalid, res, hsp, np);
      send_txn(tpid, addr, endp, tvalid, int'($urandom_range(2, 15)), dpid, n, dvalid,
               int'($urandom_range(0, 2)));
      n_checks++;
      if (obs_puts != np) begin n_fail++; $display("FAIL rnd%0d_puts: got %0d want %0d", it, obs_puts, np); end
      bad = 0;
      for (int i = 0; i < np && i < obs_puts; i++) if (put_q[obs_base + i] !== pay[i]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL rnd%0d_data: got %0d bad bytes want 0", it, bad); end
      n_checks++;
      if (obs_commit != int'(res == 1) || obs_abort != int'(res == 2)) begin
        n_fail++; $display("FAIL rnd%0d_result: got c=%0d a=%0d want res=%0d", it, obs_commit, obs_abort, res);
      end
      n_checks++;
      if (obs_hs != int'(hsp >= 0) || (hsp >= 0 && obs_hs_pid !== 4'(hsp))) begin
        n_fail++; $display("FAIL rnd%0d_hs: got n=%0d pid=%b want pid=%0d", it, obs_hs, obs_hs_pid, hsp);
      end
      if (res != 0) begin
        n_checks++;
        if (obs_pulse_cyc != obs_end_cyc + 2) begin
          n_fail++; $display("FAIL rnd%0d_latency: got +%0d want +2", it, obs_pulse_cyc - obs_end_cyc);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; dev_addr = 7'd5;
    rx_pkt_start = 1'b0; rx_pkt_end = 1'b0; rx_pid = '0; rx_addr = '0; rx_endp = '0;
    rx_valid_packet = 1'b0; rx_data_put = 1'b0; rx_data = '0;
    ep_out_ready = '1; ep_stall = '0; hs_ack = 1'b0;
    test_reset();
    test_out_ack();
    test_retransmit();
    test_nak_stall();
    test_setup();
    test_babble_badcrc();
    test_addr_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_fs_out_ctrl.md
# usb_fs_out_ctrl

Protocol controller for the OUT/SETUP receive path of the full-speed USB device core. Sits in the `clk` domain directly after `usb_fs_rx` and tracks each token/data transaction. Matches the device address, forwards payload bytes to the selected endpoint buffer and keeps per-endpoint data toggles. It then decides the handshake (ACK/NAK/STALL/none) to request from the transmit side.

## Interface
- `NUM_EP`, 4: number of OUT endpoints (1..16); endpoints ≥ NUM_EP are ignored.
- `MAX_PKT`, 64: maximum data payload bytes, excluding CRC16.
- `TIMEOUT`, 64: clk cycles allowed between token end and data packet start.
- `clk` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `dev_addr` in 7: current device address.
- `rx_pkt_start`, `rx_pkt_end` in 1: single-cycle strobes from the receiver.
- `rx_pid` in 4, `rx_addr` in 7, `rx_endp` in 4: packet fields, valid on the `rx_pkt_end` cycle.
- `rx_valid_packet` in 1: level; PID/CRC check result; sampled one cycle after `rx_pkt_end`.
- `rx_data_put` in 1, `rx_data` in 8: received data bytes (includes 2 CRC bytes).
- `ep_out_ready` in NUM_EP: endpoint buffer can take a full packet.
- `ep_stall` in NUM_EP: endpoint halted.
- `ep_sel` out 4: target endpoint of the current transaction.
- `ep_data_put` out 1, `ep_data` out 8: payload byte write strobe and byte.
- `ep_commit` out 1: pulse; keep the written bytes.
- `ep_abort` out 1: pulse; discard the written bytes.
- `ep_setup` out 1: current transaction is SETUP; held until the commit or abort pulse.
- `hs_req` out 1, `hs_pid` out 4: handshake request; held until `hs_ack`.
- `hs_ack` in 1: transmitter accepted the request.

## Operation
- PIDs: OUT 0001, SETUP 1101, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
- States: IDLE, TOKEN_CHK, DATA_WAIT, DATA_RX, DATA_CHK, HS.
- IDLE → TOKEN_CHK on `rx_pkt_end` with `rx_pid` OUT or SETUP. All other PIDs are ignored.
- TOKEN_CHK (1 cycle): proceed only if `rx_valid_packet`, `rx_addr == dev_addr` and `rx_endp < NUM_EP`; else IDLE.
  - On proceed: latch `ep_sel`, set `ep_setup` for SETUP, clear the byte counter, go to DATA_WAIT.
- DATA_WAIT: `rx_pkt_start` → DATA_RX. The timeout counter reaching TIMEOUT → IDLE, with no outputs.
- DATA_RX: bytes are delayed by a 2-byte holding pipe, so the CRC16 bytes are never forwarded.
  - Each forwarded byte issues `ep_data_put` and increments the counter (8 bits).
  - A byte that would make the count exceed MAX_PKT sets a babble flag and suppresses further puts.
  - `rx_pkt_end` → DATA_CHK.
- DATA_CHK (1 cycle, samples `rx_valid_packet`), first match wins:
  - Invalid packet, non-DATA PID, or babble: `ep_abort`, no handshake.
  - SETUP: if `ep_out_ready`, `ep_commit`, ACK, and toggle[ep] ← 1. Otherwise `ep_abort`, no handshake. Stall is ignored and not cleared.
  - OUT with `ep_stall`: `ep_abort`, STALL.
  - OUT with `ep_out_ready` low: `ep_abort`, NAK.
  - OUT with DATA PID matching toggle[ep]: `ep_commit`, ACK, toggle flips.
  - OUT with mismatched DATA PID (retransmission): `ep_abort`, ACK, toggle unchanged.
- HS: `hs_req` is held until `hs_ack`, then IDLE. Tokens arriving in HS are ignored.
- `rx_pkt_start` in TOKEN_CHK or DATA_RX (framing error): `ep_abort` if any byte was put, then IDLE.
- Reset state: IDLE; all toggles 0; every output 0.

## Timing
- `ep_data_put` and `ep_data` lag the corresponding `rx_data_put` by 1 cycle. They are registered and only issued for payload bytes.
- `ep_commit` or `ep_abort` pulses 2 cycles after the data `rx_pkt_end`.
- `hs_req` rises in the same cycle as that pulse, stays high until the cycle after `hs_ack`, then drops.
- `ep_setup` clears with the commit or abort pulse.
- Asserting `reset_n` low mid-transaction clears everything immediately. No commit or abort is issued; the endpoint buffers are reset by the same `reset_n`.

## Configuration
- `USB_OUT_TOGGLE_EN` defined: per-endpoint data toggle tracking and retransmission detection, as above.
- Undefined: there is no toggle state. Any valid DATA0/DATA1 packet on a ready, non-stalled endpoint is committed and ACKed.

## Test plan
- `dev_addr`=5, OUT addr 5 ep 1, DATA0 with 3 bytes 11 22 33 plus CRC, ready=1 → 3 `ep_data_put` (11, 22, 33), `ep_commit`, `hs_pid`=0010, toggle[1]=1.
- Repeat the same DATA0 → `ep_abort`, ACK, toggle[1] stays 1 (with `USB_OUT_TOGGLE_EN`). Without the macro: commit and ACK.
- OUT to ep 2 with `ep_out_ready[2]`=0 → `ep_abort`, NAK. With `ep_stall[2]`=1 → `ep_abort`, STALL.
- SETUP addr 5 ep 0, DATA0 with 8 bytes → `ep_setup`=1, 8 puts, commit, ACK, toggle[0]=1. Repeat with `ep_stall[0]`=1 → still ACK.
- OUT followed by DATA1 with 65 payload bytes, or with a bad CRC (`rx_valid_packet`=0) → 64 puts max, `ep_abort`, no `hs_req`.
- OUT to addr 6, then OUT to addr 5 with no data for 64 cycles → no outputs in either case; returns to IDLE.
